// File: rtl/fir_pkg.sv
// Shared types and width defaults for the FIR filter family.
// Holds the sequencer state encoding and the accumulator sizing rule.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_RES_W  = 21;
  localparam int FIR_ADDR_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } fir_state_t;

  // Wide enough that TAPS full-scale products can never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Arithmetic right shift then clamp of a wide accumulator to a signed OUT_W result.
// Purely combinational, zero latency; no flow control.
module fir_sat
  import fir_pkg::*;
#(
  parameter int IN_W  = 37,
  parameter int OUT_W = FIR_RES_W,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] res
);

  logic signed [IN_W-1:0] shifted;
  logic                   in_range;

  assign shifted = acc >>> SHIFT;

  // Representable in OUT_W bits exactly when all bits above the result sign agree with it.
  assign in_range = (shifted[IN_W-1:OUT_W-1] == '0) || (&shifted[IN_W-1:OUT_W-1]);

  always_comb begin
    if (in_range) begin
      res = shifted[OUT_W-1:0];
    end else if (shifted[IN_W-1]) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Serial FIR MAC engine: one saturated result per TAPS+2 cycles, written to the output RAM.
// No backpressure: the result write port always accepts; start is only taken in IDLE.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int ADDR_W = FIR_ADDR_W,
  parameter int RES_W  = FIR_RES_W,
  parameter int TAPS   = 32,
  parameter int SHIFT  = 15
) (
  input  logic                     a_clk,
  input  logic                     a_rst_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          n_samples,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        smp_addr,
  input  logic [DATA_W-1:0]        smp_data,
  output logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [ADDR_W-1:0]        res_addr,
  output logic [RES_W-1:0]         res_data,
  output logic                     res_wr
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int K_W    = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [K_W-1:0]          K_LAST    = K_W'(TAPS - 1);
  localparam logic signed [ADDR_W+1:0] DIFF_ZERO = '0;

  fir_state_t state, state_nxt;

  logic [ADDR_W:0]            n;
  logic [ADDR_W:0]            n_len;
  logic [ADDR_W:0]            n_inc;
  logic [K_W-1:0]             k;
  logic signed [ACC_W-1:0]    acc;
  logic                       v;
  logic signed [ADDR_W+1:0]   diff;
  logic signed [PROD_W-1:0]   prod;
  logic signed [RES_W-1:0]    sat_res;

  assign n_inc = n + (ADDR_W+1)'(1);
  assign diff  = $signed({1'b0, n}) - $signed({{(ADDR_W+2-K_W){1'b0}}, k});

  // v was registered alongside the address, so it lines up with the returning read data.
  assign prod = v ? '0 : PROD_W'($signed(smp_data)) * PROD_W'($signed(coef_data));

  always_ff @(posedge a_clk) begin
    if (!a_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_samples == '0) ? DONE : MAC;
      MAC:     if (k == K_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = (n_inc == n_len) ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    smp_addr  = '0;
    coef_addr = '0;
    res_wr    = 1'b0;
    res_addr  = '0;
    res_data  = '0;
    case (state)
      MAC: begin
        busy      = 1'b1;
        smp_addr  = diff[ADDR_W-1:0];
        coef_addr = k;
      end
      DRAIN: busy = 1'b1;
      WRITE: begin
        busy     = 1'b1;
        res_wr   = 1'b1;
        res_addr = n[ADDR_W-1:0];
        res_data = sat_res;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (!a_rst_n) begin
      n     <= '0;
      n_len <= '0;
      k     <= '0;
      acc   <= '0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_len <= n_samples;
            n     <= '0;
            k     <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          v <= (diff < DIFF_ZERO);
          k <= (k == K_LAST) ? '0 : k + K_W'(1);
          // Tap 0's data is still in flight on the first MAC cycle.
          if (k != '0) acc <= acc + ACC_W'(prod);
        end
        DRAIN: acc <= acc + ACC_W'(prod);
        WRITE: begin
          acc <= '0;
          n   <= n_inc;
        end
        default: ;
      endcase
    end
  end

  fir_sat #(
    .IN_W  (ACC_W),
    .OUT_W (RES_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc (acc),
    .res (sat_res)
  );

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: two instances (SHIFT=0 and SHIFT=15) share RAM models and stimulus;
// results are compared with a direct convolution computed from the RAM contents.
module tb_fir_mac_engine;

  localparam int TAPS   = 32;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int RES_W  = 21;
  localparam int CW     = $clog2(TAPS);
  localparam int PER    = TAPS + 2;
  localparam int SH1    = 15;

  logic a_clk   = 1'b0;
  logic a_rst_n = 1'b0;
  logic start   = 1'b0;
  logic [ADDR_W:0] n_samples = '0;

  logic              busy0, done0, res_wr0, busy1, done1, res_wr1;
  logic [ADDR_W-1:0] smp_addr0, res_addr0, smp_addr1, res_addr1;
  logic [CW-1:0]     coef_addr0, coef_addr1;
  logic [DATA_W-1:0] smp_data0 = '0, smp_data1 = '0;
  logic [COEF_W-1:0] coef_data0 = '0, coef_data1 = '0;
  logic [RES_W-1:0]  res_data0, res_data1;

  logic signed [DATA_W-1:0] smp_mem  [0:(1<<ADDR_W)-1];
  logic signed [COEF_W-1:0] coef_mem [0:TAPS-1];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t wq0[$];
  wr_t wq1[$];
  int done_cnt, done_cyc, busy_cnt, viol, first_wr_cyc;

  typedef struct {
    int pat; int ns;
    int i0; int e0; int i1; int e1; int i2; int e2;
    int si; int se;
  } vec_t;
  vec_t tbl [3];

  fir_mac_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .RES_W(RES_W),
                   .TAPS(TAPS), .SHIFT(0)) dut0 (
    .a_clk(a_clk), .a_rst_n(a_rst_n), .start(start), .n_samples(n_samples),
    .busy(busy0), .done(done0), .smp_addr(smp_addr0), .smp_data(smp_data0),
    .coef_addr(coef_addr0), .coef_data(coef_data0), .res_addr(res_addr0),
    .res_data(res_data0), .res_wr(res_wr0));

  fir_mac_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .RES_W(RES_W),
                   .TAPS(TAPS), .SHIFT(SH1)) dut1 (
    .a_clk(a_clk), .a_rst_n(a_rst_n), .start(start), .n_samples(n_samples),
    .busy(busy1), .done(done1), .smp_addr(smp_addr1), .smp_data(smp_data1),
    .coef_addr(coef_addr1), .coef_data(coef_data1), .res_addr(res_addr1),
    .res_data(res_data1), .res_wr(res_wr1));

  always #5 a_clk = ~a_clk;

  // 1-cycle-latency read ports
  always @(posedge a_clk) begin
    smp_data0  <= smp_mem[smp_addr0];
    coef_data0 <= coef_mem[coef_addr0];
    smp_data1  <= smp_mem[smp_addr1];
    coef_data1 <= coef_mem[coef_addr1];
    cyc        <= cyc + 1;
  end

  always @(negedge a_clk) begin
    if (res_wr0) begin
      if (wq0.size() == 0) first_wr_cyc = cyc;
      wq0.push_back('{int'(res_addr0), int'($signed(res_data0))});
    end
    if (res_wr1) wq1.push_back('{int'(res_addr1), int'($signed(res_data1))});
    if (done0) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy0) busy_cnt++;
    if (!res_wr0 && (res_addr0 != '0 || res_data0 != '0)) viol++;
    if (!busy0 && (smp_addr0 != '0 || coef_addr0 != '0)) viol++;
    if (done0 && res_wr0) viol++;
    if (busy0 != busy1 || done0 != done1 || res_wr0 != res_wr1) viol++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model(input int n, input int sh);
    longint acc = 0;
    longint hi = (longint'(1) <<< (RES_W - 1)) - 1;
    longint lo = -(longint'(1) <<< (RES_W - 1));
    for (int k = 0; k < TAPS; k++)
      if (n - k >= 0) acc += longint'(smp_mem[n - k]) * longint'(coef_mem[k]);
    acc = acc >>> sh;
    if (acc > hi) acc = hi;
    else if (acc < lo) acc = lo;
    return acc;
  endfunction

  function automatic int res_at(input int which, input int idx);
    if (which == 0) return (idx < wq0.size()) ? wq0[idx].data : -99999999;
    return (idx < wq1.size()) ? wq1[idx].data : -99999999;
  endfunction

  task automatic load(input int pat);
    for (int i = 0; i < 64; i++) begin
      case (pat)
        0:       smp_mem[i] = (i == 0) ? 16'sd1 : 16'sd0;
        1:       smp_mem[i] = 16'sd100;
        2:       smp_mem[i] = -16'sd32768;
        3:       smp_mem[i] = DATA_W'($urandom_range(200) - 100);
        default: smp_mem[i] = DATA_W'($urandom);
      endcase
    end
    for (int k = 0; k < TAPS; k++) begin
      case (pat)
        0:       coef_mem[k] = COEF_W'(k + 1);
        1:       coef_mem[k] = 16'sd1000;
        2:       coef_mem[k] = 16'sd32767;
        3:       coef_mem[k] = COEF_W'($urandom_range(200) - 100);
        default: coef_mem[k] = COEF_W'($urandom);
      endcase
    end
  endtask

  task automatic clear_mon();
    wq0.delete();
    wq1.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    viol = 0;
    first_wr_cyc = -1;
  endtask

  task automatic launch(input int ns, output int c0);
    @(negedge a_clk);
    clear_mon();
    n_samples = ns[ADDR_W:0];
    start = 1'b1;
    c0 = cyc;
    @(negedge a_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int ns);
    int i = 0;
    while (done_cnt == 0 && i < ns * PER + 20) begin
      @(negedge a_clk);
      i++;
    end
    repeat (3) @(negedge a_clk);
  endtask

  task automatic verify(input string tag, input int ns, input int c0);
    check({tag, " write count"}, wq0.size(), ns);
    check({tag, " write count s15"}, wq1.size(), ns);
    for (int i = 0; i < ns && i < wq0.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wq0[i].addr, i);
      check($sformatf("%s res[%0d]", tag, i), wq0[i].data, model(i, 0));
    end
    for (int i = 0; i < ns && i < wq1.size(); i++)
      check($sformatf("%s s15 res[%0d]", tag, i), wq1[i].data, model(i, SH1));
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " done cycle"}, done_cyc, c0 + ns * PER + 1);
    check({tag, " busy cycles"}, busy_cnt, ns * PER + 1);
    check({tag, " first write cycle"}, first_wr_cyc, (ns > 0) ? c0 + PER : -1);
    check({tag, " idle output violations"}, viol, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lim;
    for (int i = 0; i < (1 << ADDR_W); i++) smp_mem[i] = 16'sd777;
    for (int k = 0; k < TAPS; k++) coef_mem[k] = '0;

    tbl[0] = '{0, 40, 0, 1, 31, 32, 32, 0, 31, 0};
    tbl[1] = '{1, 40, 9, 1000000, 10, 1048575, 39, 1048575, 39, 97};
    tbl[2] = '{2, 40, 0, -1048576, 1, -1048576, 39, -1048576, 0, -32767};

    clear_mon();
    repeat (3) @(negedge a_clk);
    check("reset outputs", {busy0, done0, res_wr0, smp_addr0, coef_addr0, res_addr0, res_data0}, 0);
    check("reset outputs s15", {busy1, done1, res_wr1, smp_addr1, coef_addr1, res_addr1, res_data1}, 0);
    a_rst_n = 1'b1;
    repeat (2) @(negedge a_clk);

    for (int t = 0; t < 3; t++) begin
      load(tbl[t].pat);
      launch(tbl[t].ns, c0);
      wait_done(tbl[t].ns);
      check($sformatf("vec%0d probe res[%0d]", t, tbl[t].i0), res_at(0, tbl[t].i0), tbl[t].e0);
      check($sformatf("vec%0d probe res[%0d]", t, tbl[t].i1), res_at(0, tbl[t].i1), tbl[t].e1);
      check($sformatf("vec%0d probe res[%0d]", t, tbl[t].i2), res_at(0, tbl[t].i2), tbl[t].e2);
      check($sformatf("vec%0d s15 probe res[%0d]", t, tbl[t].si), res_at(1, tbl[t].si), tbl[t].se);
      verify($sformatf("vec%0d", t), tbl[t].ns, c0);
    end

    // zero-length run
    launch(0, c0);
    wait_done(0);
    verify("zero length", 0, c0);

    // start re-pulsed mid-run, then again in the DONE cycle
    load(3);
    launch(10, c0);
    repeat (20) @(negedge a_clk);
    n_samples = 14'd3;
    start = 1'b1;
    @(negedge a_clk);
    start = 1'b0;
    lim = 0;
    while (!done0 && lim < 10 * PER + 20) begin
      @(negedge a_clk);
      lim++;
    end
    n_samples = 14'd5;
    start = 1'b1;
    @(negedge a_clk);
    start = 1'b0;
    check("start in DONE ignored", busy0, 0);
    repeat (2) @(negedge a_clk);
    verify("repulse", 10, c0);

    // reset during the WRITE of n=5
    load(1);
    launch(10, c0);
    lim = 0;
    while (!(res_wr0 && res_addr0 == 13'd5) && lim < 10 * PER) begin
      @(negedge a_clk);
      lim++;
    end
    a_rst_n = 1'b0;
    @(negedge a_clk);
    check("mid-run reset outputs", {busy0, done0, res_wr0, smp_addr0, coef_addr0, res_addr0, res_data0}, 0);
    check("mid-run reset outputs s15", {busy1, done1, res_wr1, smp_addr1, coef_addr1, res_addr1, res_data1}, 0);
    check("writes before reset", wq0.size(), 6);
    repeat (2) @(negedge a_clk);
    a_rst_n = 1'b1;
    repeat (PER + 5) @(negedge a_clk);
    check("no done after reset", done_cnt, 0);
    check("no writes after reset", wq0.size(), 6);
    launch(10, c0);
    wait_done(10);
    verify("after reset", 10, c0);

    // randomized runs, small and full-scale operands
    for (int r = 0; r < 4; r++) begin
      int ns;
      ns = $urandom_range(64, 33);
      load(3 + (r % 2));
      launch(ns, c0);
      wait_done(ns);
      verify($sformatf("random%0d", r), ns, c0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
